// File: rtl/cdb_pkg.sv
// Purpose: shared sizes, tag constants, broadcast record type and bus slice helpers for the CDB arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cdb_pkg;

    localparam int WORD_SIZE   = 32;
    localparam int RB_INDEX    = 4;
    localparam int FU_NUM      = 6;
    localparam int STORER_NUM  = 2;
    localparam int CDB_PORTS   = 2;
    localparam int FU_ID_W     = $clog2(FU_NUM);
    // Storers occupy the top STORER_NUM requester slots.
    localparam int STORER_BASE = FU_NUM - STORER_NUM;

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [RB_INDEX-1:0]  rb_tag_t;
    typedef logic [FU_ID_W-1:0]   fu_id_t;

    // All-ones tag marks "no result"; a requester must never present it.
    localparam rb_tag_t NULL_TAG = '1;

    // One broadcast slot, minus the optional store address.
    typedef struct packed {
        fu_id_t  fu_id;
        rb_tag_t tag;
        word_t   data;
    } cdb_meta_t;

    function automatic word_t fu_word(input logic [FU_NUM*WORD_SIZE-1:0] bus, input fu_id_t id);
        return bus[int'(id)*WORD_SIZE +: WORD_SIZE];
    endfunction

    function automatic rb_tag_t fu_tag_of(input logic [FU_NUM*RB_INDEX-1:0] bus, input fu_id_t id);
        return bus[int'(id)*RB_INDEX +: RB_INDEX];
    endfunction

    // Store address of requester id, or 0 when id is not a storer.
    function automatic word_t storer_addr(input logic [STORER_NUM*WORD_SIZE-1:0] bus, input fu_id_t id);
        int j;
        j = int'(id) - STORER_BASE;
        if (j < 0)
            return '0;
        return bus[j*WORD_SIZE +: WORD_SIZE];
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Purpose: rotate-and-pick-N; grants the first CDB_PORTS requesters found scanning up from rr_ptr.
// Latency: purely combinational.
// Backpressure: none itself; unpicked requesters simply see no grant and keep requesting.
// Ports: req/rr_ptr in; grant (per FU), port_vld/port_id (n-th pick -> port n), rr_next out.
module cdb_rr_picker #(
    parameter int FU_NUM    = 6,
    parameter int CDB_PORTS = 2,
    parameter int ID_W      = $clog2(FU_NUM)
) (
    input  logic [FU_NUM-1:0]    req,
    input  logic [ID_W-1:0]      rr_ptr,
    output logic [FU_NUM-1:0]    grant,
    output logic [CDB_PORTS-1:0] port_vld,
    output logic [ID_W-1:0]      port_id [CDB_PORTS],
    output logic [ID_W-1:0]      rr_next
);

    localparam int CNT_W = $clog2(CDB_PORTS + 1);

    logic [ID_W:0]      pos;
    logic [ID_W:0]      nxt;
    logic [ID_W-1:0]    last;
    logic [CNT_W-1:0]   cnt;

    always_comb begin
        grant    = '0;
        port_vld = '0;
        for (int k = 0; k < CDB_PORTS; k++)
            port_id[k] = '0;
        pos  = '0;
        nxt  = '0;
        last = '0;
        cnt  = '0;

        for (int off = 0; off < FU_NUM; off++) begin
            // rr_ptr + off < 2*FU_NUM, so a single conditional subtract wraps it.
            pos = {1'b0, rr_ptr} + (ID_W+1)'(off);
            if (pos >= (ID_W+1)'(FU_NUM))
                pos = pos - (ID_W+1)'(FU_NUM);
            if (req[pos[ID_W-1:0]] && (cnt < CNT_W'(CDB_PORTS))) begin
                grant[pos[ID_W-1:0]] = 1'b1;
                for (int k = 0; k < CDB_PORTS; k++) begin
                    if (cnt == CNT_W'(k)) begin
                        port_vld[k] = 1'b1;
                        port_id[k]  = pos[ID_W-1:0];
                    end
                end
                cnt  = cnt + 1'b1;
                last = pos[ID_W-1:0];
            end
        end

        nxt = {1'b0, last} + 1'b1;
        if (nxt >= (ID_W+1)'(FU_NUM))
            nxt = '0;
        rr_next = (cnt != '0) ? nxt[ID_W-1:0] : rr_ptr;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Purpose: common data bus arbiter; round-robin grants up to CDB_PORTS FU results per cycle onto registered CDB ports.
// Latency: 1 cycle from fu_req&fu_ack to cdb_valid; each result is valid for exactly one cycle.
// Backpressure: losing FUs see fu_ack=0 and hold req/payload; flush or reset forces fu_ack=0.
// Ports: clk, reset (async, active-high), flush; fu_req/fu_data/fu_tag/fu_addr in, fu_ack out;
//        cdb_valid/cdb_tag/cdb_data/cdb_addr/cdb_fu_id out, packed per port.
// Config: define CDB_ADDR_EN to broadcast storer addresses; otherwise cdb_addr is tied to 0.
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [FU_NUM-1:0]                fu_req,
    input  logic [FU_NUM*WORD_SIZE-1:0]      fu_data,
    input  logic [FU_NUM*RB_INDEX-1:0]       fu_tag,
    input  logic [STORER_NUM*WORD_SIZE-1:0]  fu_addr,
    output logic [FU_NUM-1:0]                fu_ack,
    output logic [CDB_PORTS-1:0]             cdb_valid,
    output logic [CDB_PORTS*RB_INDEX-1:0]    cdb_tag,
    output logic [CDB_PORTS*WORD_SIZE-1:0]   cdb_data,
    output logic [CDB_PORTS*WORD_SIZE-1:0]   cdb_addr,
    output logic [CDB_PORTS*FU_ID_W-1:0]     cdb_fu_id
);

    fu_id_t                rr_ptr;
    fu_id_t                rr_next;
    logic [FU_NUM-1:0]     grant;
    logic [CDB_PORTS-1:0]  port_vld;
    fu_id_t                port_id [CDB_PORTS];
    cdb_meta_t             meta_q  [CDB_PORTS];
    logic                  grant_en;

    cdb_rr_picker #(
        .FU_NUM    (FU_NUM),
        .CDB_PORTS (CDB_PORTS),
        .ID_W      (FU_ID_W)
    ) u_picker (
        .req      (fu_req),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .port_vld (port_vld),
        .port_id  (port_id),
        .rr_next  (rr_next)
    );

    // Reset is included so acks drop the instant reset rises, not at the next edge.
    assign grant_en = ~reset & ~flush;
    assign fu_ack   = grant & {FU_NUM{grant_en}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            cdb_valid <= '0;
            for (int k = 0; k < CDB_PORTS; k++)
                meta_q[k] <= '0;
        end else if (flush) begin
            // Nothing was acked this cycle; pointer and stale fields stay put.
            cdb_valid <= '0;
        end else begin
            rr_ptr    <= rr_next;
            cdb_valid <= port_vld;
            for (int k = 0; k < CDB_PORTS; k++) begin
                if (port_vld[k]) begin
                    meta_q[k].fu_id <= port_id[k];
                    meta_q[k].tag   <= fu_tag_of(fu_tag, port_id[k]);
                    meta_q[k].data  <= fu_word(fu_data, port_id[k]);
                end
            end
        end
    end

    for (genvar k = 0; k < CDB_PORTS; k++) begin : g_port
        assign cdb_tag[k*RB_INDEX +: RB_INDEX]    = meta_q[k].tag;
        assign cdb_data[k*WORD_SIZE +: WORD_SIZE] = meta_q[k].data;
        assign cdb_fu_id[k*FU_ID_W +: FU_ID_W]    = meta_q[k].fu_id;
    end

`ifdef CDB_ADDR_EN
    word_t addr_q [CDB_PORTS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < CDB_PORTS; k++)
                addr_q[k] <= '0;
        end else if (!flush) begin
            for (int k = 0; k < CDB_PORTS; k++) begin
                if (port_vld[k])
                    addr_q[k] <= storer_addr(fu_addr, port_id[k]);
            end
        end
    end

    for (genvar k = 0; k < CDB_PORTS; k++) begin : g_addr
        assign cdb_addr[k*WORD_SIZE +: WORD_SIZE] = addr_q[k];
    end
`else
    logic fu_addr_unused;
    assign fu_addr_unused = ^fu_addr;
    assign cdb_addr       = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic                             clk   = 1'b0;
    logic                             reset = 1'b0;
    logic                             flush = 1'b0;
    logic [FU_NUM-1:0]                fu_req = '0;
    logic [FU_NUM*WORD_SIZE-1:0]      fu_data;
    logic [FU_NUM*RB_INDEX-1:0]       fu_tag;
    logic [STORER_NUM*WORD_SIZE-1:0]  fu_addr;
    logic [FU_NUM-1:0]                fu_ack;
    logic [CDB_PORTS-1:0]             cdb_valid;
    logic [CDB_PORTS*RB_INDEX-1:0]    cdb_tag;
    logic [CDB_PORTS*WORD_SIZE-1:0]   cdb_data;
    logic [CDB_PORTS*WORD_SIZE-1:0]   cdb_addr;
    logic [CDB_PORTS*FU_ID_W-1:0]     cdb_fu_id;

    cdb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .fu_req    (fu_req),
        .fu_data   (fu_data),
        .fu_tag    (fu_tag),
        .fu_addr   (fu_addr),
        .fu_ack    (fu_ack),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_addr  (cdb_addr),
        .cdb_fu_id (cdb_fu_id)
    );

    always #5 clk = ~clk;

    // Per-FU payload table: distinct, non-null tags.
    rb_tag_t tag_a  [FU_NUM]     = '{4'd1, 4'd2, 4'd5, 4'd7, 4'd9, 4'd11};
    word_t   data_a [FU_NUM]     = '{32'h1111_0000, 32'h2222_0001, 32'h0000_DEAD,
                                     32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    word_t   addr_a [STORER_NUM] = '{32'h0000_0200, 32'h0000_0100};

    typedef struct {
        int      port;
        int      fu;
        rb_tag_t tag;
        word_t   data;
        word_t   addr;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic word_t exp_addr(input int fu);
`ifdef CDB_ADDR_EN
        if (fu >= STORER_BASE)
            return addr_a[fu - STORER_BASE];
`endif
        return '0;
    endfunction

    task automatic push(input int port, input int fu);
        exp_t e;
        e.port = port;
        e.fu   = fu;
        e.tag  = tag_a[fu];
        e.data = data_a[fu];
        e.addr = exp_addr(fu);
        sb.push_back(e);
    endtask

    // Called at posedge+1: drive, check combinational ack, advance one edge.
    task automatic step(input logic [FU_NUM-1:0] req, input logic fl,
                        input logic [FU_NUM-1:0] exp_ack, input string name);
        fu_req = req;
        flush  = fl;
        #2;
        check({"ack_", name}, 64'(fu_ack), 64'(exp_ack));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard for every valid port, in port order.
    always @(negedge clk) begin
        if (!reset) begin
            n_tests++;
            if ((fu_ack & ~fu_req) != '0) begin
                n_fail++;
                $display("FAIL ack_without_req: ack %b req %b", fu_ack, fu_req);
            end
            for (int k = 0; k < CDB_PORTS; k++) begin
                if (cdb_valid[k]) begin
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_cdb: port %0d fu %0d tag %0h with nothing expected",
                                 k, cdb_fu_id[k*FU_ID_W +: FU_ID_W], cdb_tag[k*RB_INDEX +: RB_INDEX]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if (e.port != k ||
                            cdb_fu_id[k*FU_ID_W +: FU_ID_W] != fu_id_t'(e.fu) ||
                            cdb_tag[k*RB_INDEX +: RB_INDEX] != e.tag ||
                            cdb_data[k*WORD_SIZE +: WORD_SIZE] != e.data ||
                            cdb_addr[k*WORD_SIZE +: WORD_SIZE] != e.addr) begin
                            n_fail++;
                            $display("FAIL cdb_port: got port %0d fu %0d tag %0h data %0h addr %0h, expected port %0d fu %0d tag %0h data %0h addr %0h",
                                     k, cdb_fu_id[k*FU_ID_W +: FU_ID_W], cdb_tag[k*RB_INDEX +: RB_INDEX],
                                     cdb_data[k*WORD_SIZE +: WORD_SIZE], cdb_addr[k*WORD_SIZE +: WORD_SIZE],
                                     e.port, e.fu, e.tag, e.data, e.addr);
                        end
                    end
                end
            end
        end
    end

    // Stimulus protocol guard: requesters never present the null tag or duplicate tags.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FU_NUM; i++) begin
                if (fu_req[i]) begin
                    assert (fu_tag[i*RB_INDEX +: RB_INDEX] != NULL_TAG)
                        else $error("protocol: FU %0d requests with null tag", i);
                    for (int j = i + 1; j < FU_NUM; j++)
                        if (fu_req[j])
                            assert (fu_tag[i*RB_INDEX +: RB_INDEX] != fu_tag[j*RB_INDEX +: RB_INDEX])
                                else $error("protocol: FU %0d and %0d share a tag", i, j);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < FU_NUM; i++) begin
            fu_tag[i*RB_INDEX +: RB_INDEX]    = tag_a[i];
            fu_data[i*WORD_SIZE +: WORD_SIZE] = data_a[i];
        end
        for (int i = 0; i < STORER_NUM; i++)
            fu_addr[i*WORD_SIZE +: WORD_SIZE] = addr_a[i];

        // Reset asserted mid-cycle with every FU requesting.
        fu_req = '1;
        #2 reset = 1'b1;
        #1;
        check("rst_ack",   64'(fu_ack),    64'(0));
        check("rst_valid", 64'(cdb_valid), 64'(0));
        check("rst_tag",   64'(cdb_tag),   64'(0));
        check("rst_data",  64'(cdb_data),  64'(0));
        check("rst_addr",  64'(cdb_addr),  64'(0));
        check("rst_fu_id", 64'(cdb_fu_id), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Contention from rr_ptr=0: {0,1},{2,3},{4,5},{0,1}.
        push(0, 0); push(1, 1); step(6'b111111, 1'b0, 6'b000011, "cont0");
        push(0, 2); push(1, 3); step(6'b111111, 1'b0, 6'b001100, "cont1");
        push(0, 4); push(1, 5); step(6'b111111, 1'b0, 6'b110000, "cont2");
        push(0, 0); push(1, 1); step(6'b111111, 1'b0, 6'b000011, "cont3");

        // Single FU2 (rr_ptr=2): port0 only; port1 keeps FU1's fields.
        push(0, 2); step(6'b000100, 1'b0, 6'b000100, "single");
        check("single_valid", 64'(cdb_valid), 64'(2'b01));
        check("hold_port1_tag", 64'(cdb_tag[RB_INDEX +: RB_INDEX]), 64'(tag_a[1]));

        // FU4 alone moves rr_ptr to 5.
        push(0, 4); step(6'b010000, 1'b0, 6'b010000, "to_ptr5");

        // Wrap: FU5, FU0 this cycle, FU3 next; rr_ptr 1 then 4.
        push(0, 5); push(1, 0); step(6'b101001, 1'b0, 6'b100001, "wrap");
        push(0, 3); step(6'b001000, 1'b0, 6'b001000, "wrap_fu3");
        // From rr_ptr=4, requesters {2,4,5} must yield 4 and 5.
        push(0, 4); push(1, 5); step(6'b110100, 1'b0, 6'b110000, "ptr_is4");

        // Flush blocks grants and leaves rr_ptr at 0.
        step(6'b010010, 1'b1, 6'b000000, "flush");
        check("flush_valid", 64'(cdb_valid), 64'(0));
        push(0, 1); push(1, 4); step(6'b010010, 1'b0, 6'b010010, "post_flush");

        // Storers: rr_ptr=5 -> FU5 alone, then {4,5} from rr_ptr=0.
        push(0, 5); step(6'b100000, 1'b0, 6'b100000, "store5");
        check("store5_addr", 64'(cdb_addr[0 +: WORD_SIZE]), 64'(exp_addr(5)));
        push(0, 4); push(1, 5); step(6'b110000, 1'b0, 6'b110000, "store45");

        step(6'b000000, 1'b0, 6'b000000, "idle");
        check("idle_valid", 64'(cdb_valid), 64'(0));

        // Reset mid-transfer: rr_ptr is 4 and FU2/FU3 are held when reset rises.
        push(0, 2); push(1, 3); step(6'b001100, 1'b0, 6'b001100, "pre_reset");
        #5 reset = 1'b1;
        #1;
        check("midrst_ack",   64'(fu_ack),    64'(0));
        check("midrst_valid", 64'(cdb_valid), 64'(0));
        check("midrst_data",  64'(cdb_data),  64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        // rr_ptr back at 0: requesters {0,2,4} yield 0 and 2.
        push(0, 0); push(1, 2); step(6'b010101, 1'b0, 6'b000101, "after_reset");

        step(6'b000000, 1'b0, 6'b000000, "drain");
        #10;
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
